// File: rtl/azdle_time_set_ctrl_pkg.sv
// azdle_time_set_ctrl_pkg: shared state encoding, time limits and wrap helper
package azdle_time_set_ctrl_pkg;
  typedef enum logic [1:0] {RUN, SET_H, SET_M, COMMIT} state_e;
  localparam int HOURS_MAX = 24;
  localparam int MINUTES_MAX = 60;
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input int max);
    return (int'(v) >= max - 1) ? 6'd0 : v + 6'd1;
  endfunction
endpackage

// File: rtl/azdle_debounce.sv
// azdle_debounce: two-flop synchroniser, level debouncer and one-cycle press pulse
module azdle_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, level_q, armed_q, press_q, flip;
  logic [CW-1:0] cnt_q;
  assign flip = (s2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign press_o = press_q;
  // Synchroniser resets to "pressed" so a button held across reset never arms;
  // arming needs a synchronised release, and only armed rising levels pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      cnt_q   <= (s2_q == level_q || flip) ? '0 : cnt_q + CW'(1);
      level_q <= level_q ^ flip;
      armed_q <= armed_q | ~s2_q;
      press_q <= flip & ~level_q & armed_q;
    end
  end
endmodule

// File: rtl/azdle_time_set_ctrl.sv
// azdle_time_set_ctrl: two-button time-setting controller with blinking edit field
module azdle_time_set_ctrl
  import azdle_time_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int BLINK_BITS      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [4:0]  cur_hours,
  input  logic [5:0]  cur_minutes,
  output logic        run_en,
  output logic        load_en,
  output logic [4:0]  load_hours,
  output logic [5:0]  load_minutes,
  output logic [4:0]  show_hours,
  output logic [5:0]  show_minutes,
  output logic [10:0] disp_mask
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic mode_p, inc_p, editing, timeout;
  state_e state_q, state_d;
  logic [4:0] edit_h_q, edit_h_d, show_h_q;
  logic [5:0] edit_m_q, edit_m_d, show_m_q;
  logic [IW-1:0] idle_q, idle_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic load_en_q, run_en_q;
  logic [10:0] mask_q;

  azdle_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_mode), .press_o(mode_p)
  );
  azdle_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_inc), .press_o(inc_p)
  );

  // Next-state decode; mode wins over inc because it is tested first.
  always_comb begin
    editing  = state_q == SET_H || state_q == SET_M;
    timeout  = idle_q == IW'(TIMEOUT_CYCLES - 1);
    idle_d   = (!editing || mode_p || inc_p) ? '0 : idle_q + IW'(1);
    blink_d  = blink_q + BLINK_BITS'(1);
    state_d  = state_q;
    edit_h_d = edit_h_q;
    edit_m_d = edit_m_q;
    case (state_q)
      RUN: if (mode_p) begin
        state_d  = SET_H;
        edit_h_d = (cur_hours >= 5'(HOURS_MAX)) ? '0 : cur_hours;
        edit_m_d = (cur_minutes >= 6'(MINUTES_MAX)) ? '0 : cur_minutes;
      end
      SET_H: if (mode_p) state_d = SET_M;
        else if (inc_p) edit_h_d = 5'(wrap_inc({1'b0, edit_h_q}, HOURS_MAX));
        else if (timeout) state_d = RUN;
      SET_M: if (mode_p) state_d = COMMIT;
        else if (inc_p) edit_m_d = wrap_inc(edit_m_q, MINUTES_MAX);
        else if (timeout) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State and all outputs registered from next-state values, so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      edit_h_q  <= '0;
      edit_m_q  <= '0;
      idle_q    <= '0;
      blink_q   <= '0;
      load_en_q <= 1'b0;
      run_en_q  <= 1'b1;
      show_h_q  <= '0;
      show_m_q  <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      edit_h_q  <= edit_h_d;
      edit_m_q  <= edit_m_d;
      idle_q    <= idle_d;
      blink_q   <= blink_d;
      load_en_q <= state_d == COMMIT;
      run_en_q  <= state_d == RUN;
      show_h_q  <= (state_d == RUN) ? cur_hours : edit_h_d;
      show_m_q  <= (state_d == RUN) ? cur_minutes : edit_m_d;
      mask_q    <= {{5{!(state_d == SET_H && blink_d[BLINK_BITS-1])}},
                    {6{!(state_d == SET_M && blink_d[BLINK_BITS-1])}}};
    end
  end

  assign run_en       = run_en_q;
  assign load_en      = load_en_q;
  assign load_hours   = edit_h_q;
  assign load_minutes = edit_m_q;
  assign show_hours   = show_h_q;
  assign show_minutes = show_m_q;
  assign disp_mask    = mask_q;
endmodule
